// File: rtl/back_end_axi_read.sv
// rtl/back_end_axi_read.sv - AXI4 read back end filling one cache line per INCR burst, with bounded re-issue on error
module back_end_axi_read #(
    parameter int FE_ADDR_W   = 32,
    parameter int FE_DATA_W   = 32,
    parameter int BE_ADDR_W   = FE_ADDR_W,
    parameter int BE_DATA_W   = FE_DATA_W,
    parameter int WORD_OFF_W  = 3,
    parameter int AXI_ID_W    = 1,
    parameter int AXI_ID      = 0,
    parameter int MAX_RETRY   = 2,
    localparam int BE_BYTE_W   = $clog2(BE_DATA_W / 8),
    localparam int LINE2MEM_W  = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int LINE_ADDR_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   replace_valid,
    input  logic [LINE_ADDR_W-1:0] replace_addr,
    output logic                   replace_ready,
    output logic                   read_valid,
    output logic [LINE2MEM_W-1:0]  read_addr,
    output logic [BE_DATA_W-1:0]   read_rdata,
    output logic                   axi_arvalid,
    output logic [BE_ADDR_W-1:0]   axi_araddr,
    output logic [7:0]             axi_arlen,
    output logic [2:0]             axi_arsize,
    output logic [1:0]             axi_arburst,
    output logic                   axi_arlock,
    output logic [3:0]             axi_arcache,
    output logic [2:0]             axi_arprot,
    output logic [3:0]             axi_arqos,
    output logic [AXI_ID_W-1:0]    axi_arid,
    input  logic                   axi_arready,
    input  logic                   axi_rvalid,
    input  logic [BE_DATA_W-1:0]   axi_rdata,
    input  logic [1:0]             axi_rresp,
    input  logic                   axi_rlast,
    output logic                   axi_rready
);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state, state_nxt;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [LINE2MEM_W-1:0]  beat_cnt;
    logic [RETRY_W-1:0]     retry_cnt;
    logic                   err_q;
    logic                   err_now;
    logic                   retry_go;
    logic [FE_ADDR_W-1:0]   line_byte_addr;
    logic                   unused_rresp_lsb;

    // Only SLVERR/DECERR matter; OKAY vs EXOKAY is irrelevant for a line fill.
    assign unused_rresp_lsb = axi_rresp[0];
    assign err_now          = err_q | axi_rresp[1];
    assign retry_go         = err_now && (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (replace_valid) state_nxt = ADDR;
            ADDR: if (axi_arready)   state_nxt = DATA;
            DATA: if (axi_rvalid && axi_rlast) state_nxt = retry_go ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        replace_ready = 1'b0;
        axi_arvalid   = 1'b0;
        axi_rready    = 1'b0;
        read_valid    = 1'b0;
        case (state)
            IDLE: replace_ready = 1'b1;
            ADDR: axi_arvalid   = 1'b1;
            DATA: begin
                axi_rready = 1'b1;
                read_valid = axi_rvalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            beat_cnt  <= '0;
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (replace_valid) begin
                    addr_q    <= replace_addr;
                    beat_cnt  <= '0;
                    retry_cnt <= '0;
                    err_q     <= 1'b0;
                end
                DATA: if (axi_rvalid) begin
                    if (axi_rlast && retry_go) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        err_q     <= 1'b0;
                        beat_cnt  <= '0;
                    end else begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        err_q     <= err_now;
                    end
                end
                default: ;
            endcase
        end
    end

    assign line_byte_addr = {addr_q, {(BE_BYTE_W + LINE2MEM_W){1'b0}}};
    assign axi_araddr     = BE_ADDR_W'(line_byte_addr);
    assign axi_arlen      = 8'(2 ** LINE2MEM_W - 1);
    assign axi_arsize     = 3'(BE_BYTE_W);
    assign axi_arburst    = 2'b01;
    assign axi_arlock     = 1'b0;
    assign axi_arcache    = 4'b0011;
    assign axi_arprot     = 3'b000;
    assign axi_arqos      = 4'b0000;
    assign axi_arid       = AXI_ID_W'(AXI_ID);
    assign read_addr      = beat_cnt;
    assign read_rdata     = axi_rdata;

endmodule

// File: doc/back_end_axi_read.md
BACK_END_AXI_READ -- requirements
Module: back_end_axi_read

Interface
REQ-001 Parameter FE_ADDR_W, default 32, front-end byte-address width.
REQ-002 Parameter FE_DATA_W, default 32, front-end word width.
REQ-003 Parameter BE_ADDR_W, default FE_ADDR_W, AXI address width.
REQ-004 Parameter BE_DATA_W, default FE_DATA_W, AXI data width; a power of 2 and at least FE_DATA_W.
REQ-005 Parameter WORD_OFF_W, default 3, log2 of FE words per cache line.
REQ-006 Parameter AXI_ID_W, default 1, AXI ID width.
REQ-007 Parameter AXI_ID, default 0, AXI ID value driven on axi_arid.
REQ-008 Parameter MAX_RETRY, default 2, maximum burst re-issues per line after an error response.
REQ-009 Derived values:
- BE_BYTE_W = log2(BE_DATA_W/8).
- LINE2MEM_W = WORD_OFF_W - log2(BE_DATA_W/FE_DATA_W).
- LINE2MEM_W SHALL be at least 1.
REQ-010 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- replace_valid  in  1  line-fill request.
- replace_addr  in  FE_ADDR_W-BE_BYTE_W-LINE2MEM_W  line address.
- replace_ready  out  1  idle, request accepted.
- read_valid  out  1  line beat valid.
- read_addr  out  LINE2MEM_W  beat index within the line.
- read_rdata  out  BE_DATA_W  beat data.
REQ-011 AXI read ports (name, direction, width):
- axi_arvalid out 1; axi_araddr out BE_ADDR_W; axi_arlen out 8.
- axi_arsize out 3; axi_arburst out 2; axi_arlock out 1.
- axi_arcache out 4; axi_arprot out 3; axi_arqos out 4.
- axi_arid out AXI_ID_W; axi_arready in 1.
- axi_rvalid in 1; axi_rdata in BE_DATA_W; axi_rresp in 2.
- axi_rlast in 1; axi_rready out 1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-013 replace_ready SHALL be 1 in IDLE and 0 in every other state.
REQ-014 In IDLE with replace_valid=1, the block SHALL register replace_addr, clear the beat counter, clear the retry counter and the error flag, and enter ADDR on the next edge.
REQ-015 In ADDR, axi_arvalid SHALL be 1; all AR fields SHALL stay stable until axi_arready=1, at which edge the FSM SHALL enter DATA.
REQ-016 axi_araddr SHALL be {registered replace_addr, BE_BYTE_W+LINE2MEM_W zeros}, zero-extended or truncated to BE_ADDR_W.
REQ-017 Constant AR fields:
- axi_arlen = 2**LINE2MEM_W-1; axi_arsize = BE_BYTE_W; axi_arburst = 2'b01 (INCR).
- axi_arlock = 0; axi_arcache = 4'b0011; axi_arprot = 3'b000; axi_arqos = 0.
- axi_arid = AXI_ID.
REQ-018 axi_rready SHALL be 1 in DATA only.
REQ-019 In DATA, read_valid SHALL equal axi_rvalid and read_rdata SHALL equal axi_rdata, both combinationally; read_addr SHALL equal the beat counter.
REQ-020 The beat counter SHALL increment on every accepted beat (axi_rvalid in DATA), wrap modulo 2**LINE2MEM_W, and reset to 0 on entering ADDR.
REQ-021 The error flag SHALL set on any accepted beat with axi_rresp[1]=1 (SLVERR/DECERR), that beat included.
REQ-022 On the accepted beat with axi_rlast=1, the next state is decided as follows:
- If the error flag, including the current beat, is set and the retry counter < MAX_RETRY: increment the retry counter, clear the error flag, go to ADDR with the same address.
- Otherwise: go to IDLE.
REQ-023 axi_rlast is authoritative: a burst SHALL end only on rlast regardless of the counter value, and beats beyond 2**LINE2MEM_W wrap read_addr.
REQ-024 Outside DATA, read_valid SHALL be 0 and axi_rvalid SHALL be ignored.
REQ-025 replace_valid SHALL be ignored outside IDLE.
REQ-026 Minimum latency from replace_valid to the first read_valid SHALL be 2 cycles: IDLE→ADDR, then ADDR→DATA with arready=1, first rvalid in DATA.

Reset
REQ-027 While reset=0, regardless of state:
- The FSM SHALL be IDLE; counters, error flag and stored address SHALL be 0.
- axi_arvalid=0, axi_rready=0, read_valid=0, replace_ready=1.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; outstanding R beats after reset release SHALL be ignored while IDLE.

Verification
REQ-029 Defaults, replace_addr=0x1234567 (bits [31:5]):
- Stimulus: replace_valid pulse, arready=1, 8 OKAY beats 0xA0..0xA7 with rlast on the 8th.
- Required: araddr=0x2468ACE0, arlen=7, arsize=2, arburst=01; read_addr 0..7 with matching data; replace_ready returns to 1 after the last beat.
REQ-030 arready held low 5 cycles:
- Required: arvalid stays 1 and araddr stays stable for all 5 cycles; DATA entered only on the arready edge.
REQ-031 SLVERR on beat 3 of the first burst, then a clean second burst:
- Required: exactly 2 AR handshakes with the same address; 16 read_valid pulses total; IDLE after the second rlast.
REQ-032 Every burst erroneous with MAX_RETRY=2:
- Required: exactly 3 AR handshakes, then IDLE; no deadlock.
REQ-033 reset=0 asserted after beat 4, then released:
- Required: same cycle: arvalid=0, rready=0, read_valid=0, replace_ready=1.
- After release: rvalid pulses produce no read_valid.
REQ-034 BE_DATA_W=64, WORD_OFF_W=3:
- Required: LINE2MEM_W=2, arlen=3, arsize=3, read_addr cycles 0..3.
